// File: rtl/csr_sequencer.sv
// Sequences Zicsr ops and trap entry onto the machine-mode CSR file over its shared
// tri-state data bus: read, optional turnaround, optional write, then a one-cycle response.
module csr_sequencer #(
    parameter int TURNAROUND_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_src,
    input  logic [4:0]  req_zimm,
    input  logic        req_rs1_zero,
    input  logic        req_rd_zero,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_illegal,
    input  logic        trap_req,
    input  logic [4:0]  trap_cause_in,
    input  logic [31:0] trap_pc,
    output logic        trap_ack,
    output logic [11:0] csr_addr,
    inout  wire  [31:0] csr_bus,
    output logic        csr_read,
    output logic        csr_write,
    output logic [1:0]  csr_write_type,
    output logic        csr_trap,
    output logic [4:0]  csr_trap_cause,
    input  logic        csr_invalid
);

    // state | meaning
    // IDLE  | waiting; trap_req wins over req_valid
    // READ  | csr_read, capture old value and invalid flag
    // TURN  | bus released between read and write
    // WRITE | drive operand, csr_write
    // TRAP  | drive trap pc, csr_trap, trap_ack
    // RESP  | rsp_valid pulse
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        TURN  = 3'd2,
        WRITE = 3'd3,
        TRAP  = 3'd4,
        RESP  = 3'd5
    } state_t;

    localparam logic [1:0] TURN_LOAD = 2'(TURNAROUND_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  wtype_q;
    logic [11:0] addr_q;
    logic [31:0] operand_q;
    logic        rs1_zero_q;
    logic [31:0] rdata_q, rdata_d;
    logic        illegal_q, illegal_d;
    logic [1:0]  turn_cnt_q, turn_cnt_d;
    logic [31:0] trap_pc_q;
    logic [4:0]  trap_cause_q;

    logic        accept;
    logic        acc_do_read;
    logic        lat_do_write;
    logic        trap_take;
    logic        bus_oe;
    logic [31:0] bus_dout;

    assign req_ready    = (state_q == IDLE) & ~trap_req & ~rst;
    assign accept       = req_valid & req_ready;
    assign trap_take    = (state_q == IDLE) & trap_req;
    // CSRRW/CSRRWI with rd=x0 must not read (no side effects of the read)
    assign acc_do_read  = ~((req_funct3[1:0] == 2'b01) & req_rd_zero);
    assign lat_do_write = (wtype_q == 2'b01) | ~rs1_zero_q;

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        illegal_d  = illegal_q;
        turn_cnt_d = turn_cnt_q;
        case (state_q)
            IDLE: begin
                if (trap_req) begin
                    state_d = TRAP;
                end else if (req_valid) begin
                    rdata_d   = 32'h0;
                    illegal_d = 1'b0;
                    state_d   = acc_do_read ? READ : WRITE;
                end
            end
            READ: begin
                rdata_d   = csr_bus;
                illegal_d = csr_invalid;
                if (csr_invalid) begin
                    state_d = RESP;
                end else if (lat_do_write) begin
                    if (TURNAROUND_CYCLES == 0) begin
                        state_d = WRITE;
                    end else begin
                        state_d    = TURN;
                        turn_cnt_d = TURN_LOAD;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            TURN: begin
                if (turn_cnt_q == 2'd0) begin
                    state_d = WRITE;
                end else begin
                    turn_cnt_d = turn_cnt_q - 2'd1;
                end
            end
            WRITE: begin
                illegal_d = csr_invalid;
                state_d   = RESP;
            end
            TRAP:    state_d = IDLE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wtype_q      <= 2'b00;
            addr_q       <= 12'h0;
            operand_q    <= 32'h0;
            rs1_zero_q   <= 1'b0;
            rdata_q      <= 32'h0;
            illegal_q    <= 1'b0;
            turn_cnt_q   <= 2'd0;
            trap_pc_q    <= 32'h0;
            trap_cause_q <= 5'h0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            illegal_q  <= illegal_d;
            turn_cnt_q <= turn_cnt_d;
            if (accept) begin
                wtype_q    <= req_funct3[1:0];
                addr_q     <= req_addr;
                operand_q  <= req_funct3[2] ? {27'b0, req_zimm} : req_src;
                rs1_zero_q <= req_rs1_zero;
            end
            // trap_req is a held level, so the IDLE-cycle values are the ones for TRAP
            if (trap_take) begin
                trap_pc_q    <= trap_pc;
                trap_cause_q <= trap_cause_in;
            end
        end
    end

    assign csr_read       = (state_q == READ);
    assign csr_write      = (state_q == WRITE);
    assign csr_trap       = (state_q == TRAP);
    assign trap_ack       = (state_q == TRAP);
    assign rsp_valid      = (state_q == RESP);
    assign rsp_illegal    = (state_q == RESP) & illegal_q;
    assign rsp_rdata      = rdata_q;
    assign csr_addr       = addr_q;
    assign csr_write_type = wtype_q;
    assign csr_trap_cause = trap_cause_q;

    assign bus_oe   = (state_q == WRITE) | (state_q == TRAP);
    assign bus_dout = (state_q == TRAP) ? trap_pc_q : operand_q;
    assign csr_bus  = bus_oe ? bus_dout : 32'bz;

endmodule

// File: tb/tb_csr_sequencer.sv
// Directed bench for csr_sequencer with a small machine-mode CSR file on the shared bus.
module tb_csr_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_src;
    logic [4:0]  req_zimm;
    logic        req_rs1_zero;
    logic        req_rd_zero;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;
    logic        trap_req;
    logic [4:0]  trap_cause_in;
    logic [31:0] trap_pc;
    logic        trap_ack;
    logic [11:0] csr_addr;
    wire  [31:0] csr_bus;
    logic        csr_read;
    logic        csr_write;
    logic [1:0]  csr_write_type;
    logic        csr_trap;
    logic [4:0]  csr_trap_cause;
    logic        csr_invalid;

    int n_cmp = 0;
    int n_bad = 0;

    csr_sequencer #(.TURNAROUND_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_src(req_src),
        .req_zimm(req_zimm), .req_rs1_zero(req_rs1_zero), .req_rd_zero(req_rd_zero),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
        .trap_req(trap_req), .trap_cause_in(trap_cause_in), .trap_pc(trap_pc),
        .trap_ack(trap_ack),
        .csr_addr(csr_addr), .csr_bus(csr_bus), .csr_read(csr_read),
        .csr_write(csr_write), .csr_write_type(csr_write_type),
        .csr_trap(csr_trap), .csr_trap_cause(csr_trap_cause),
        .csr_invalid(csr_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file: mscratch 0x340, mepc 0x341, mcause 0x342; anything else is invalid
    logic [31:0] m_scratch, m_epc, m_cause, m_rd, m_new;
    logic        m_valid;

    always_comb begin
        m_valid = 1'b1;
        m_rd    = 32'h0;
        case (csr_addr)
            12'h340: m_rd = m_scratch;
            12'h341: m_rd = m_epc;
            12'h342: m_rd = m_cause;
            default: m_valid = 1'b0;
        endcase
        case (csr_write_type)
            2'b10:   m_new = m_rd | csr_bus;
            2'b11:   m_new = m_rd & ~csr_bus;
            default: m_new = csr_bus;
        endcase
    end

    assign csr_invalid = (csr_read | csr_write) & ~m_valid;
    assign csr_bus     = csr_read ? m_rd : 32'bz;

    always @(posedge clk) begin
        if (rst) begin
            m_scratch <= 32'h0;
            m_epc     <= 32'h0;
            m_cause   <= 32'h0;
        end else begin
            if (csr_write && m_valid) begin
                case (csr_addr)
                    12'h340: m_scratch <= m_new;
                    12'h341: m_epc     <= m_new;
                    12'h342: m_cause   <= m_new;
                    default: ;
                endcase
            end
            if (csr_trap) begin
                m_epc   <= csr_bus;
                m_cause <= {27'b0, csr_trap_cause};
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] src,
                         input logic [4:0] zimm, input logic rs1z, input logic rdz);
        int w;
        req_funct3   = f3;
        req_addr     = addr;
        req_src      = src;
        req_zimm     = zimm;
        req_rs1_zero = rs1z;
        req_rd_zero  = rdz;
        req_valid    = 1'b1;
        #1;
        w = 0;
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        check_val("issue_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic collect(output int rd_c, output int wr_c, output int lat,
                           output logic [31:0] rdata, output logic [31:0] wdata,
                           output logic ill, output logic [1:0] wt);
        rd_c = 0; wr_c = 0; lat = 0;
        rdata = 32'h0; wdata = 32'h0; ill = 1'b0; wt = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            if (csr_read && rd_c == 0) rd_c = k;
            if (csr_write && wr_c == 0) begin
                wr_c  = k;
                wdata = csr_bus;
                wt    = csr_write_type;
            end
            if (rsp_valid) begin
                lat   = k;
                rdata = rsp_rdata;
                ill   = rsp_illegal;
                tick();
                check_val("rsp_single_pulse", 32'(rsp_valid), 32'd0);
                break;
            end
            tick();
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                          input logic [31:0] src, input logic [4:0] zimm,
                          input logic rs1z, input logic rdz,
                          input int e_rd, input int e_wr, input int e_lat,
                          input logic [31:0] e_rdata, input logic e_ill,
                          input logic [31:0] e_wdata, input logic [1:0] e_wt);
        int rd_c, wr_c, lat;
        logic [31:0] rdata, wdata;
        logic ill;
        logic [1:0] wt;
        issue(f3, addr, src, zimm, rs1z, rdz);
        collect(rd_c, wr_c, lat, rdata, wdata, ill, wt);
        check_val({tag, ".read_cycle"}, 32'(rd_c), 32'(e_rd));
        check_val({tag, ".write_cycle"}, 32'(wr_c), 32'(e_wr));
        check_val({tag, ".latency"}, 32'(lat), 32'(e_lat));
        check_val({tag, ".rdata"}, rdata, e_rdata);
        check_val({tag, ".illegal"}, 32'(ill), 32'(e_ill));
        if (e_wr != 0) begin
            check_val({tag, ".wdata"}, wdata, e_wdata);
            check_val({tag, ".wtype"}, 32'(wt), 32'(e_wt));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_rsp, saw_wr;
        int rd_c, wr_c, lat;
        logic [31:0] rdata, wdata;
        logic ill;
        logic [1:0] wt;

        rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'b000; req_addr = 12'h0;
        req_src = 32'h0; req_zimm = 5'h0; req_rs1_zero = 1'b0; req_rd_zero = 1'b0;
        trap_req = 1'b0; trap_cause_in = 5'h0; trap_pc = 32'h0;
        tick(); tick();

        check_val("reset.req_ready", 32'(req_ready), 32'd0);
        check_val("reset.strobes", {27'b0, rsp_valid, csr_read, csr_write, csr_trap, trap_ack}, 32'd0);
        check_val("reset.rsp_rdata", rsp_rdata, 32'h0);
        check_val("reset.csr_addr", 32'(csr_addr), 32'h0);
        check_val("reset.wtype_cause", {25'b0, csr_write_type, csr_trap_cause}, 32'h0);
        rst = 1'b0;
        tick();

        //      tag       f3      addr     src           zimm  rs1z rdz  rd wr lat rdata          ill wdata          wt
        run_op("csrrw",   3'b001, 12'h340, 32'hDEADBEEF, 5'd0,  0, 0,   1, 3, 4, 32'h0,         0, 32'hDEADBEEF, 2'b01);
        run_op("reread",  3'b010, 12'h340, 32'h0,        5'd0,  1, 0,   1, 0, 2, 32'hDEADBEEF,  0, 32'h0,        2'b00);
        run_op("rd_mepc", 3'b010, 12'h341, 32'h0,        5'd0,  1, 0,   1, 0, 2, 32'h0,         0, 32'h0,        2'b00);
        run_op("csrrwi",  3'b101, 12'h340, 32'hFFFFFFFF, 5'd5,  0, 1,   0, 1, 2, 32'h0,         0, 32'h5,        2'b01);
        run_op("csrrsi",  3'b110, 12'h340, 32'hFFFFFFFF, 5'hA,  0, 0,   1, 3, 4, 32'h5,         0, 32'hA,        2'b10);
        run_op("csrrc",   3'b011, 12'h340, 32'h3,        5'd0,  0, 0,   1, 3, 4, 32'hF,         0, 32'h3,        2'b11);
        run_op("illegal", 3'b011, 12'h7C0, 32'h1,        5'd0,  0, 0,   1, 0, 2, 32'h0,         1, 32'h0,        2'b00);
        run_op("rd_scr",  3'b010, 12'h340, 32'h0,        5'd0,  1, 0,   1, 0, 2, 32'hC,         0, 32'h0,        2'b00);

        // trap and CSR request arrive together; trap goes first
        trap_req = 1'b1; trap_cause_in = 5'd11; trap_pc = 32'h100;
        req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 12'h342;
        req_src = 32'h0; req_zimm = 5'h0; req_rs1_zero = 1'b1; req_rd_zero = 1'b0;
        #1;
        check_val("trap.ready_blocked", 32'(req_ready), 32'd0);
        tick();
        check_val("trap.ack", 32'(trap_ack), 32'd1);
        check_val("trap.csr_trap", 32'(csr_trap), 32'd1);
        check_val("trap.cause", 32'(csr_trap_cause), 32'd11);
        check_val("trap.bus_pc", csr_bus, 32'h100);
        check_val("trap.no_read", 32'(csr_read), 32'd0);
        trap_req = 1'b0;
        #1;
        check_val("trap.ready_in_trap", 32'(req_ready), 32'd0);
        tick();
        check_val("trap.ready_after", 32'(req_ready), 32'd1);
        check_val("trap.ack_pulse", 32'(trap_ack), 32'd0);
        tick();
        req_valid = 1'b0;
        collect(rd_c, wr_c, lat, rdata, wdata, ill, wt);
        check_val("trap.mcause_read", rdata, 32'd11);
        check_val("trap.mcause_latency", 32'(lat), 32'd2);
        run_op("rd_mepc2", 3'b010, 12'h341, 32'h0, 5'd0, 1, 0, 1, 0, 2, 32'h100, 0, 32'h0, 2'b00);

        // reset lands while the sequencer sits in TURN
        issue(3'b001, 12'h340, 32'h12345678, 5'd0, 1'b0, 1'b0);
        check_val("rstturn.read", 32'(csr_read), 32'd1);
        tick();
        check_val("rstturn.turn_quiet", {30'b0, csr_read, csr_write}, 32'd0);
        rst = 1'b1;
        tick();
        check_val("rstturn.strobes", {27'b0, rsp_valid, csr_read, csr_write, csr_trap, trap_ack}, 32'd0);
        check_val("rstturn.ready_in_rst", 32'(req_ready), 32'd0);
        rst = 1'b0;
        saw_rsp = 1'b0;
        saw_wr  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (rsp_valid) saw_rsp = 1'b1;
            if (csr_write) saw_wr = 1'b1;
            tick();
        end
        check_val("rstturn.no_rsp", 32'(saw_rsp), 32'd0);
        check_val("rstturn.no_write", 32'(saw_wr), 32'd0);
        check_val("rstturn.idle_ready", 32'(req_ready), 32'd1);
        run_op("rd_after_rst", 3'b010, 12'h340, 32'h0, 5'd0, 1, 0, 1, 0, 2, 32'h0, 0, 32'h0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
